// File: rtl/bti_pkg.sv
// Shared BTI definitions: default field widths and the host-index width helper.
package bti_pkg;

  localparam int BTI_AW_DEF = 32;
  localparam int BTI_DW_DEF = 32;
  localparam int BTI_BYTE_W = 8;

  // Width of an index over n items; never narrower than one bit.
  function automatic int hid_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bti_ord_fifo.sv
// In-order tag FIFO with a fall-through head; storage is left unreset.
module bti_ord_fifo
  import bti_pkg::*;
#(
  parameter int DW    = 1,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = hid_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [2**PW];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rptr];

  // Pointer and occupancy tracking; simultaneous push/pop leaves the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Tag storage write.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/bti_arbiter.sv
// Round-robin arbiter sharing one BTI guest among HOST_NUM hosts; responses
// are routed back by host tags kept in an in-order FIFO.
module bti_arbiter
  import bti_pkg::*;
#(
  parameter int BTI_AW    = BTI_AW_DEF,
  parameter int BTI_DW    = BTI_DW_DEF,
  parameter int HOST_NUM  = 2,
  parameter int OST_DEPTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [HOST_NUM-1:0]                         i_host_req_vld,
  output logic [HOST_NUM-1:0]                         o_host_req_rdy,
  input  logic [HOST_NUM-1:0][BTI_AW-1:0]             i_host_req_addr,
  input  logic [HOST_NUM-1:0]                         i_host_req_wr,
  input  logic [HOST_NUM-1:0][BTI_DW-1:0]             i_host_req_wdata,
  input  logic [HOST_NUM-1:0][BTI_DW/BTI_BYTE_W-1:0]  i_host_req_wstrb,
  output logic [HOST_NUM-1:0]                         o_host_rsp_vld,
  input  logic [HOST_NUM-1:0]                         i_host_rsp_rdy,
  output logic [HOST_NUM-1:0][BTI_DW-1:0]             o_host_rsp_rdata,
  output logic                                        o_gst_req_vld,
  input  logic                                        i_gst_req_rdy,
  output logic [BTI_AW-1:0]                           o_gst_req_addr,
  output logic                                        o_gst_req_wr,
  output logic [BTI_DW-1:0]                           o_gst_req_wdata,
  output logic [BTI_DW/BTI_BYTE_W-1:0]                o_gst_req_wstrb,
  input  logic                                        i_gst_rsp_vld,
  output logic                                        o_gst_rsp_rdy,
  input  logic [BTI_DW-1:0]                           i_gst_rsp_rdata
);

  localparam int HID_W = hid_w(HOST_NUM);

  logic [HID_W-1:0] r_rr_ptr;
  logic [HID_W-1:0] r_gnt_q;
  logic             r_lock;
  logic [HID_W-1:0] w_pick;
  logic [HID_W-1:0] w_gnt;
  logic [HID_W-1:0] w_rr_next;
  logic [HID_W-1:0] w_head;
  logic             w_found;
  int               w_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_req_hs;
  logic             w_rsp_hs;

  // Round-robin pick: first requester at or after rr_ptr, modulo HOST_NUM.
  always_comb begin
    w_pick  = r_rr_ptr;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < HOST_NUM; i++) begin
      w_idx = (int'(r_rr_ptr) + i) % HOST_NUM;
      if (!w_found && i_host_req_vld[w_idx]) begin
        w_found = 1'b1;
        w_pick  = HID_W'(w_idx);
      end
    end
  end

  assign w_gnt     = r_lock ? r_gnt_q : w_pick;
  assign w_rr_next = (w_gnt == HID_W'(HOST_NUM - 1)) ? '0 : w_gnt + HID_W'(1);
  assign w_req_hs  = o_gst_req_vld && i_gst_req_rdy;
  assign w_rsp_hs  = i_gst_rsp_vld && o_gst_rsp_rdy;

  // Request forwarding and response steering; everything is quiet while in reset.
  always_comb begin
    o_gst_req_vld   = !rst && i_host_req_vld[w_gnt] && !w_full;
    o_gst_req_addr  = i_host_req_addr[w_gnt];
    o_gst_req_wr    = i_host_req_wr[w_gnt];
    o_gst_req_wdata = i_host_req_wdata[w_gnt];
    o_gst_req_wstrb = i_host_req_wstrb[w_gnt];
    o_gst_rsp_rdy   = !rst && !w_empty && i_host_rsp_rdy[w_head];
    for (int h = 0; h < HOST_NUM; h++) begin
      o_host_req_rdy[h]   = !rst && (w_gnt == HID_W'(h)) && i_gst_req_rdy && !w_full;
      o_host_rsp_vld[h]   = !rst && !w_empty && (w_head == HID_W'(h)) && i_gst_rsp_vld;
      o_host_rsp_rdata[h] = i_gst_rsp_rdata;
    end
  end

  // Priority pointer rotation and grant lock while the guest stalls a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_gnt_q  <= '0;
      r_lock   <= 1'b0;
    end else begin
      r_lock <= o_gst_req_vld && !i_gst_req_rdy;
      if (!r_lock) r_gnt_q <= w_gnt;
      if (w_req_hs) r_rr_ptr <= w_rr_next;
    end
  end

  bti_ord_fifo #(
    .DW    (HID_W),
    .DEPTH (OST_DEPTH)
  ) u_ord_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_req_hs),
    .i_pop   (w_rsp_hs),
    .i_din   (w_gnt),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst) !(i_gst_rsp_vld && w_empty))
    else $error("guest response with no outstanding transfer");

endmodule

// File: tb/tb_bti_arbiter.sv
// Directed bench for bti_arbiter with two hosts and four outstanding transfers.
module tb_bti_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       host_req_vld;
  logic [1:0]       host_req_rdy;
  logic [1:0][31:0] host_req_addr;
  logic [1:0]       host_req_wr;
  logic [1:0][31:0] host_req_wdata;
  logic [1:0][3:0]  host_req_wstrb;
  logic [1:0]       host_rsp_vld;
  logic [1:0]       host_rsp_rdy;
  logic [1:0][31:0] host_rsp_rdata;
  logic             gst_req_vld;
  logic             gst_req_rdy;
  logic [31:0]      gst_req_addr;
  logic             gst_req_wr;
  logic [31:0]      gst_req_wdata;
  logic [3:0]       gst_req_wstrb;
  logic             gst_rsp_vld;
  logic             gst_rsp_rdy;
  logic [31:0]      gst_rsp_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bti_arbiter #(
    .BTI_AW    (32),
    .BTI_DW    (32),
    .HOST_NUM  (2),
    .OST_DEPTH (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_host_req_vld   (host_req_vld),
    .o_host_req_rdy   (host_req_rdy),
    .i_host_req_addr  (host_req_addr),
    .i_host_req_wr    (host_req_wr),
    .i_host_req_wdata (host_req_wdata),
    .i_host_req_wstrb (host_req_wstrb),
    .o_host_rsp_vld   (host_rsp_vld),
    .i_host_rsp_rdy   (host_rsp_rdy),
    .o_host_rsp_rdata (host_rsp_rdata),
    .o_gst_req_vld    (gst_req_vld),
    .i_gst_req_rdy    (gst_req_rdy),
    .o_gst_req_addr   (gst_req_addr),
    .o_gst_req_wr     (gst_req_wr),
    .o_gst_req_wdata  (gst_req_wdata),
    .o_gst_req_wstrb  (gst_req_wstrb),
    .i_gst_rsp_vld    (gst_rsp_vld),
    .o_gst_rsp_rdy    (gst_rsp_rdy),
    .i_gst_rsp_rdata  (gst_rsp_rdata)
  );

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    host_req_vld = 2'b00;
    gst_rsp_vld  = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    host_req_vld   = 2'b11;
    host_req_addr  = '0;
    host_req_wr    = 2'b00;
    host_req_wdata = '0;
    host_req_wstrb = '0;
    host_rsp_rdy   = 2'b11;
    gst_req_rdy    = 1'b1;
    gst_rsp_vld    = 1'b0;
    gst_rsp_rdata  = '0;
    step();
    step();
    #1;
    checks++; if (host_req_rdy !== 2'b00) begin errors++; $display("FAIL reset_host_req_rdy: got %b expected 00", host_req_rdy); end
    checks++; if (host_rsp_vld !== 2'b00) begin errors++; $display("FAIL reset_host_rsp_vld: got %b expected 00", host_rsp_vld); end
    checks++; if (gst_req_vld !== 1'b0) begin errors++; $display("FAIL reset_gst_req_vld: got %b expected 0", gst_req_vld); end
    checks++; if (gst_rsp_rdy !== 1'b0) begin errors++; $display("FAIL reset_gst_rsp_rdy: got %b expected 0", gst_rsp_rdy); end
    host_req_vld = 2'b00;
  endtask

  task automatic test_single_host();
    apply_reset();
    host_req_vld     = 2'b01;
    host_req_addr[0] = 32'h0000_0100;
    host_req_wr[0]   = 1'b0;
    #1;
    checks++; if (gst_req_vld !== 1'b1) begin errors++; $display("FAIL single_gst_vld: got %b expected 1", gst_req_vld); end
    checks++; if (gst_req_addr !== 32'h100) begin errors++; $display("FAIL single_gst_addr: got %h expected 00000100", gst_req_addr); end
    checks++; if (host_req_rdy !== 2'b01) begin errors++; $display("FAIL single_host_rdy: got %b expected 01", host_req_rdy); end
    step();
    host_req_vld  = 2'b00;
    gst_rsp_vld   = 1'b1;
    gst_rsp_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (host_rsp_vld !== 2'b01) begin errors++; $display("FAIL single_rsp_vld: got %b expected 01", host_rsp_vld); end
    checks++; if (host_rsp_rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rsp_rdata: got %h expected deadbeef", host_rsp_rdata[0]); end
    checks++; if (gst_rsp_rdy !== 1'b1) begin errors++; $display("FAIL single_gst_rsp_rdy: got %b expected 1", gst_rsp_rdy); end
    step();
    gst_rsp_vld = 1'b0;
    #1;
    checks++; if (gst_rsp_rdy !== 1'b0) begin errors++; $display("FAIL single_fifo_empty: gst_rsp_rdy got %b expected 0", gst_rsp_rdy); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_onehot [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_addr  [4] = '{32'h10, 32'h20, 32'h10, 32'h20};
    apply_reset();
    host_req_addr[0] = 32'h10;
    host_req_addr[1] = 32'h20;
    host_req_vld     = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (host_req_rdy !== exp_onehot[i]) begin errors++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, host_req_rdy, exp_onehot[i]); end
      checks++; if (gst_req_addr !== exp_addr[i]) begin errors++; $display("FAIL contention_addr[%0d]: got %h expected %h", i, gst_req_addr, exp_addr[i]); end
      step();
    end
    host_req_vld = 2'b00;
    gst_rsp_vld  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gst_rsp_rdata = 32'hA0 + 32'(i);
      #1;
      checks++; if (host_rsp_vld !== exp_onehot[i]) begin errors++; $display("FAIL contention_rsp_route[%0d]: got %b expected %b", i, host_rsp_vld, exp_onehot[i]); end
      checks++; if (host_rsp_rdata[i % 2] !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL contention_rsp_rdata[%0d]: got %h expected %h", i, host_rsp_rdata[i % 2], 32'hA0 + 32'(i)); end
      step();
    end
    gst_rsp_vld = 1'b0;
    #1;
    checks++; if (gst_rsp_rdy !== 1'b0) begin errors++; $display("FAIL contention_drained: gst_rsp_rdy got %b expected 0", gst_rsp_rdy); end
  endtask

  task automatic test_stall_lock();
    apply_reset();
    gst_req_rdy       = 1'b0;
    host_req_addr[1]  = 32'h0000_2222;
    host_req_wr[1]    = 1'b1;
    host_req_wdata[1] = 32'hCAFE_0001;
    host_req_wstrb[1] = 4'b0011;
    host_req_addr[0]  = 32'h0000_0300;
    host_req_wr[0]    = 1'b0;
    host_req_vld      = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (gst_req_addr !== 32'h2222) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected 00002222", i, gst_req_addr); end
      checks++; if (gst_req_vld !== 1'b1) begin errors++; $display("FAIL stall_vld[%0d]: got %b expected 1", i, gst_req_vld); end
      checks++; if (host_req_rdy !== 2'b00) begin errors++; $display("FAIL stall_host_rdy[%0d]: got %b expected 00", i, host_req_rdy); end
      step();
      host_req_vld = 2'b11;
    end
    gst_req_rdy = 1'b1;
    #1;
    checks++; if (gst_req_addr !== 32'h2222) begin errors++; $display("FAIL stall_release_addr: got %h expected 00002222", gst_req_addr); end
    checks++; if (gst_req_wdata !== 32'hCAFE_0001) begin errors++; $display("FAIL stall_wdata: got %h expected cafe0001", gst_req_wdata); end
    checks++; if (gst_req_wstrb !== 4'b0011) begin errors++; $display("FAIL stall_wstrb: got %b expected 0011", gst_req_wstrb); end
    checks++; if (gst_req_wr !== 1'b1) begin errors++; $display("FAIL stall_wr: got %b expected 1", gst_req_wr); end
    checks++; if (host_req_rdy !== 2'b10) begin errors++; $display("FAIL stall_release_rdy: got %b expected 10", host_req_rdy); end
    step();
    host_req_vld = 2'b01;
    #1;
    checks++; if (gst_req_addr !== 32'h300) begin errors++; $display("FAIL stall_next_addr: got %h expected 00000300", gst_req_addr); end
    checks++; if (host_req_rdy !== 2'b01) begin errors++; $display("FAIL stall_next_rdy: got %b expected 01", host_req_rdy); end
    step();
    host_req_vld = 2'b00;
  endtask

  task automatic test_full();
    apply_reset();
    host_req_addr[0] = 32'h400;
    host_req_vld     = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (gst_req_vld !== 1'b1) begin errors++; $display("FAIL full_fill_vld[%0d]: got %b expected 1", i, gst_req_vld); end
      step();
    end
    #1;
    checks++; if (gst_req_vld !== 1'b0) begin errors++; $display("FAIL full_gst_vld: got %b expected 0", gst_req_vld); end
    checks++; if (host_req_rdy !== 2'b00) begin errors++; $display("FAIL full_host_rdy: got %b expected 00", host_req_rdy); end
    gst_rsp_vld   = 1'b1;
    gst_rsp_rdata = 32'h5;
    #1;
    checks++; if (gst_rsp_rdy !== 1'b1) begin errors++; $display("FAIL full_pop_rdy: got %b expected 1", gst_rsp_rdy); end
    checks++; if (gst_req_vld !== 1'b0) begin errors++; $display("FAIL full_pop_blocks: got %b expected 0", gst_req_vld); end
    step();
    gst_rsp_vld = 1'b0;
    #1;
    checks++; if (gst_req_vld !== 1'b1) begin errors++; $display("FAIL full_after_pop_vld: got %b expected 1", gst_req_vld); end
    checks++; if (host_req_rdy !== 2'b01) begin errors++; $display("FAIL full_after_pop_rdy: got %b expected 01", host_req_rdy); end
    step();
    host_req_vld = 2'b00;
  endtask

  task automatic test_back_pressure();
    apply_reset();
    host_req_addr[1] = 32'h500;
    host_req_vld     = 2'b10;
    step();
    host_req_vld  = 2'b00;
    host_rsp_rdy  = 2'b01;
    gst_rsp_vld   = 1'b1;
    gst_rsp_rdata = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (gst_rsp_rdy !== 1'b0) begin errors++; $display("FAIL bp_gst_rsp_rdy[%0d]: got %b expected 0", i, gst_rsp_rdy); end
      checks++; if (host_rsp_vld !== 2'b10) begin errors++; $display("FAIL bp_host_rsp_vld[%0d]: got %b expected 10", i, host_rsp_vld); end
      step();
    end
    host_rsp_rdy = 2'b11;
    #1;
    checks++; if (gst_rsp_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %b expected 1", gst_rsp_rdy); end
    step();
    gst_rsp_vld = 1'b0;
    #1;
    checks++; if (gst_rsp_rdy !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", gst_rsp_rdy); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    host_req_addr[0] = 32'h600;
    host_req_addr[1] = 32'h700;
    host_req_vld     = 2'b01;
    step();
    step();
    step();
    rst          = 1'b1;
    host_req_vld = 2'b11;
    step();
    #1;
    checks++; if (host_req_rdy !== 2'b00) begin errors++; $display("FAIL rmid_host_req_rdy: got %b expected 00", host_req_rdy); end
    checks++; if (gst_req_vld !== 1'b0) begin errors++; $display("FAIL rmid_gst_req_vld: got %b expected 0", gst_req_vld); end
    checks++; if (gst_rsp_rdy !== 1'b0) begin errors++; $display("FAIL rmid_gst_rsp_rdy: got %b expected 0", gst_rsp_rdy); end
    checks++; if (host_rsp_vld !== 2'b00) begin errors++; $display("FAIL rmid_host_rsp_vld: got %b expected 00", host_rsp_vld); end
    rst = 1'b0;
    #1;
    checks++; if (gst_req_addr !== 32'h600) begin errors++; $display("FAIL rmid_next_grant_addr: got %h expected 00000600", gst_req_addr); end
    checks++; if (host_req_rdy !== 2'b01) begin errors++; $display("FAIL rmid_next_grant_rdy: got %b expected 01", host_req_rdy); end
    checks++; if (gst_rsp_rdy !== 1'b0) begin errors++; $display("FAIL rmid_fifo_empty: got %b expected 0", gst_rsp_rdy); end
    host_req_vld = 2'b00;
    step();
  endtask

  initial begin
    test_reset();
    test_single_host();
    test_contention();
    test_stall_lock();
    test_full();
    test_back_pressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
